// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: state encoding, default
// widths and the timer sizing helper.
package change_dispenser_pkg;

    // Default width of change amount, inventory count and remaining count.
    localparam int unsigned CNT_W_DEFAULT = 8;

    // Controller states; encoding is fixed so other blocks can decode it.
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StCheck = 3'd1,
        StEject = 3'd2,
        StGap   = 3'd3,
        StDone  = 3'd4
    } state_t;

    // Bits needed to hold the longer of the two phase durations.
    function automatic int unsigned timer_width(input int unsigned pulse_cycles,
                                                input int unsigned gap_cycles);
        int unsigned longest;
        longest = (pulse_cycles > gap_cycles) ? pulse_cycles : gap_cycles;
        return ($clog2(longest + 1) < 1) ? 1 : $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/change_dispenser_pulse_timer.sv
// Loadable down-counter with a terminal flag; times the eject and gap phases.
module change_dispenser_pulse_timer #(
    parameter int unsigned W = 3
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    // Load on request, otherwise count down and park at zero.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    // Flag is high on the final cycle of a loaded duration.
    assign zero = (count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Coin change dispenser: ejects coins one at a time, pulses the inventory
// decrement per coin and stops early with a shortfall flag when empty.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int unsigned CNT_W        = CNT_W_DEFAULT,
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 2
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] change_amt,
    input  logic [CNT_W-1:0] coins,
    output logic             dec_sig,
    output logic             eject,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic [CNT_W-1:0] remaining
);

    localparam int unsigned TW = timer_width(PULSE_CYCLES, GAP_CYCLES);

    state_t          state;
    logic            timer_load;
    logic [TW-1:0]   timer_val;
    logic            timer_zero;

    // A loaded value of N-1 gives a phase lasting N cycles, ending when the
    // timer reads zero.
    change_dispenser_pulse_timer #(
        .W (TW)
    ) u_timer (
        .CLK      (CLK),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    // Arm the timer on entry to the eject and gap phases.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = '0;
        unique case (state)
            StCheck: begin
                if (remaining != '0 && coins != '0) begin
                    timer_load = 1'b1;
                    timer_val  = TW'(PULSE_CYCLES - 1);
                end
            end
            StEject: begin
                if (timer_zero) begin
                    timer_load = 1'b1;
                    timer_val  = TW'(GAP_CYCLES - 1);
                end
            end
            default: ;
        endcase
    end

    // Controller FSM; every output is registered alongside the state so each
    // output reflects the state it is entering.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            dec_sig   <= 1'b0;
            eject     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            short     <= 1'b0;
            remaining <= '0;
        end else begin
            dec_sig <= 1'b0;
            done    <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        remaining <= change_amt;
                        short     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= StCheck;
                    end
                end
                StCheck: begin
                    if (remaining == '0) begin
                        done  <= 1'b1;
                        state <= StDone;
                    end else if (coins == '0) begin
                        // Inventory ran dry with coins still owed.
                        short <= 1'b1;
                        done  <= 1'b1;
                        state <= StDone;
                    end else begin
                        eject   <= 1'b1;
                        dec_sig <= 1'b1;
                        state   <= StEject;
                    end
                end
                StEject: begin
                    if (timer_zero) begin
                        if (remaining != '0) begin
                            remaining <= remaining - 1'b1;
                        end
                        eject <= 1'b0;
                        state <= StGap;
                    end
                end
                StGap: begin
                    // Gap lets the inventory counter settle before re-checking.
                    if (timer_zero) begin
                        state <= StCheck;
                    end
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    eject <= 1'b0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser with a simple inventory model.
module tb_change_dispenser;

    localparam int CNT_W = 8;
    localparam int PULSE = 4;
    localparam int GAP   = 2;
    localparam int COIN_PERIOD = 1 + PULSE + GAP;

    logic             CLK;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] change_amt;
    logic [CNT_W-1:0] coins;
    logic             dec_sig;
    logic             eject;
    logic             busy;
    logic             done;
    logic             short;
    logic [CNT_W-1:0] remaining;

    logic             inv_load;
    logic [CNT_W-1:0] inv_val;

    int n_cmp;
    int n_fail;

    change_dispenser #(
        .CNT_W        (CNT_W),
        .PULSE_CYCLES (PULSE),
        .GAP_CYCLES   (GAP)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .start      (start),
        .change_amt (change_amt),
        .coins      (coins),
        .dec_sig    (dec_sig),
        .eject      (eject),
        .busy       (busy),
        .done       (done),
        .short      (short),
        .remaining  (remaining)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Coin inventory counter: loadable, decremented by each dec_sig pulse.
    always @(posedge CLK) begin
        if (inv_load) coins <= inv_val;
        else if (dec_sig && coins != '0) coins <= coins - 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic load_inventory(input int inv);
        @(negedge CLK);
        inv_load = 1'b1;
        inv_val  = CNT_W'(inv);
        @(negedge CLK);
        inv_load = 1'b0;
    endtask

    // One dispense request; expectations come from the payout rules alone.
    task automatic run_txn(input string name, input int amt, input int inv, input bit lockout);
        int k, dec_n, ej_n, last_dec, gap_bad, latency, busy0;
        int n_exp, rem_exp, short_exp, lat_exp;
        logic short_at_done;
        logic [CNT_W-1:0] rem_at_done;
        load_inventory(inv);
        start      = 1'b1;
        change_amt = CNT_W'(amt);
        @(posedge CLK);
        #1;
        start      = 1'b0;
        change_amt = CNT_W'($urandom_range(0, 255));
        k = 0; dec_n = 0; ej_n = 0; last_dec = -1; gap_bad = 0; latency = -1; busy0 = 0;
        short_at_done = 1'bx;
        rem_at_done   = 'x;
        forever begin
            @(negedge CLK);
            if (k == 0) busy0 = int'(busy);
            if (dec_sig) begin
                if (last_dec >= 0 && k - last_dec != COIN_PERIOD) gap_bad++;
                last_dec = k;
                dec_n++;
            end
            if (eject) ej_n++;
            if (lockout && k == 5) begin
                start      = 1'b1;
                change_amt = CNT_W'(9);
            end
            if (lockout && k == 6) start = 1'b0;
            if (done) begin
                latency       = k + 1;
                short_at_done = short;
                rem_at_done   = remaining;
                break;
            end
            if (k >= 400) begin
                check({name, " timeout"}, 32'(k), 32'(0));
                break;
            end
            @(posedge CLK);
            k++;
        end
        start = 1'b0;
        n_exp     = (amt < inv) ? amt : inv;
        rem_exp   = amt - n_exp;
        short_exp = (amt > inv) ? 1 : 0;
        lat_exp   = n_exp * COIN_PERIOD + 2;
        check({name, " busy_after_accept"}, 32'(busy0), 32'(1));
        check({name, " latency"}, 32'(latency), 32'(lat_exp));
        check({name, " dec_pulses"}, 32'(dec_n), 32'(n_exp));
        check({name, " eject_cycles"}, 32'(ej_n), 32'(n_exp * PULSE));
        check({name, " dec_spacing_errors"}, 32'(gap_bad), 32'(0));
        check({name, " short"}, 32'(short_at_done), 32'(short_exp));
        check({name, " remaining"}, 32'(rem_at_done), 32'(rem_exp));
        @(negedge CLK);
        check({name, " done_one_cycle"}, 32'(done), 32'(0));
        check({name, " idle_after"}, 32'(busy), 32'(0));
        check({name, " remaining_held"}, 32'(remaining), 32'(rem_exp));
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        reset      = 1'b0;
        start      = 1'b0;
        change_amt = '0;
        inv_load   = 1'b1;
        inv_val    = '0;
        repeat (3) @(negedge CLK);
        check("reset_outputs", 32'({dec_sig, eject, busy, done, short, remaining}), 32'(0));
        reset    = 1'b1;
        inv_load = 1'b0;
        @(negedge CLK);
        check("reset_idle", 32'(busy), 32'(0));

        run_txn("full_payout", 3, 10, 1'b0);
        run_txn("shortfall", 5, 2, 1'b0);
        run_txn("zero_request", 0, 7, 1'b0);
        run_txn("busy_lockout", 3, 10, 1'b1);
        run_txn("empty_inventory", 1, 0, 1'b0);

        // Asynchronous reset in the middle of an eject pulse.
        load_inventory(10);
        start      = 1'b1;
        change_amt = CNT_W'(2);
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("mid_reset_precondition_eject", 32'(eject), 32'(1));
        #2;
        reset = 1'b0;
        #1;
        check("mid_reset_outputs", 32'({dec_sig, eject, busy, done, short, remaining}), 32'(0));
        @(negedge CLK);
        reset = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check("post_reset_idle", 32'({busy, done, eject}), 32'(0));
        end
        run_txn("after_reset", 2, 5, 1'b0);

        for (int i = 0; i < 8; i++) begin
            int amt, inv;
            amt = int'($urandom_range(0, 6));
            inv = int'($urandom_range(0, 8));
            run_txn($sformatf("random%0d_amt%0d_inv%0d", i, amt, inv), amt, inv, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Dispenses change from the coin inventory, one coin at a time.
- Accepts a change amount and drives the coin ejector actuator once per coin.
- Issues one `dec_sig` pulse per ejected coin to the 8-bit coin inventory counter.
- Watches that counter's `coins` value and stops early with a shortfall flag if the inventory runs dry.

Parameters:
- CNT_W, 8, width of change amount, inventory count and remaining count.
- PULSE_CYCLES, 4, cycles `eject` is held high per coin (>=1).
- GAP_CYCLES, 2, idle cycles after each `eject` pulse before the next inventory check (>=1; guarantees the counter has applied `dec_sig`).

Ports:
- CLK  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request to dispense; sampled only in IDLE.
- change_amt  input  CNT_W  number of coins to dispense; latched on accepted start.
- coins  input  CNT_W  current inventory from the coin counter.
- dec_sig  output  1  one-cycle pulse per coin; drives the coin counter's decrement input.
- eject  output  1  actuator drive, high PULSE_CYCLES per coin.
- busy  output  1  high in every state except IDLE; system gates the coin counter's enable with ~busy.
- done  output  1  one-cycle pulse at end of operation.
- short  output  1  set if the operation ended with coins still owed.
- remaining  output  CNT_W  coins still owed.

Behaviour:
- Reset (async, reset=0): state IDLE, timer=0, and all outputs 0 (dec_sig, eject, busy, done, short, remaining).
  - Mid-operation reset drops `eject` immediately; no `done` is issued.
- All outputs are registered/Moore; no combinational input-to-output paths.
- States: IDLE, CHECK, EJECT, GAP, DONE.
- IDLE:
  - start=1 at an edge → latch `remaining` = change_amt, clear `short`, go to CHECK.
  - start while not IDLE is ignored; no queuing.
- CHECK (1 cycle):
  - remaining==0 → DONE.
  - else if coins==0 → set `short`=1, go to DONE.
  - else → EJECT with timer=0.
- EJECT:
  - `eject`=1 throughout.
  - `dec_sig`=1 only in the first EJECT cycle (timer==0).
  - Stays PULSE_CYCLES cycles.
  - On the last cycle, remaining ← remaining−1 and go to GAP.
- GAP:
  - `eject`=0 for GAP_CYCLES cycles, then CHECK.
- DONE:
  - `done`=1 for exactly one cycle, then IDLE.
  - `remaining` and `short` hold their values until the next accepted start.
- `busy` = (state != IDLE); it goes high the cycle after start is accepted.
- Timing per coin: 1 + PULSE_CYCLES + GAP_CYCLES cycles.
- Total duration: start-accept edge to done = N·(1+PULSE+GAP) + 2 cycles (final CHECK + DONE), for N coins fully paid.
- Arithmetic:
  - `remaining` never underflows; decrement occurs only when remaining>0.
  - Timer width is ceil(log2(max(PULSE_CYCLES, GAP_CYCLES)+1)).
- Inventory changing during EJECT/GAP has no effect until the next CHECK.
- change_amt=0 → CHECK → DONE; no eject; short=0.
- coins < change_amt → dispense `coins` coins, then short=1, remaining = change_amt − coins.

Decomposition:
- Shared package (vending_pkg): state encoding constants (IDLE=0, CHECK=1, EJECT=2, GAP=3, DONE=4, 3 bits) and the CNT_W default.
- Optional sub-module `pulse_timer`: loadable down-counter with a terminal flag, reusable for the EJECT and GAP durations.
- Otherwise a single FSM module.

Test Plan:
- Reset: assert reset=0 mid-EJECT with remaining=2 → eject, dec_sig, busy, done, short drop to 0 and remaining=0 immediately (asynchronously); after release, state is IDLE.
- Full payout: coins=10, start with change_amt=3 (PULSE=4, GAP=2).
  - Exactly 3 dec_sig pulses, 7 cycles apart.
  - eject high 4 cycles each.
  - done 23 cycles after start-accept edge.
  - short=0, remaining=0.
- Shortfall: coins model starts at 2, decremented by dec_sig, change_amt=5 → 2 pulses, then done; short=1, remaining=3.
- Zero request: change_amt=0 → no eject/dec_sig; done 2 cycles after accept; short=0.
- Busy lockout: start re-asserted with change_amt=9 during GAP → ignored; original count completes and remaining follows the first request only.
- Empty inventory: coins=0, change_amt=1 → no eject; done 2 cycles after accept; short=1, remaining=1.
